// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_receiver_pkg;

   localparam int unsigned DATA_W         = 8;
   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned CNT_W_DEF      = 4;
   localparam int unsigned BIT_IDX_W      = $clog2(DATA_W);

   // Codes shared with the transmitter; RX_BREAK is receive-only.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      RX_BREAK  = 3'd4
   } rx_state_e;

endpackage : uart_receiver_pkg

// File: rtl/uart_receiver_if.sv
// Line-side inputs and byte/strobe outputs of the UART receiver.
interface uart_receiver_if;
   import uart_receiver_pkg::*;

   logic              en;
   logic              rx;
   logic [DATA_W-1:0] toMem;
   logic              rxDone;
   logic              frameErr;
   logic              busy;

   modport master (output en, output rx,
                   input toMem, input rxDone, input frameErr, input busy);

   modport slave  (input en, input rx,
                   output toMem, output rxDone, output frameErr, output busy);

endinterface : uart_receiver_if

// File: rtl/uart_receiver_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_receiver_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Both stages reset to 1 so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : uart_receiver_sync2

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start detect, mid-bit sampling, stop check, break hold-off.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic            baudClk,
   input  logic            reset,
   uart_receiver_if.slave  bus
);

   localparam logic [CNT_W-1:0]     HALF_TGT = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0]     FULL_TGT = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_W - 1);
   localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

   logic rx_sync;

   rx_state_e             state_q,     state_d;
   logic [CNT_W-1:0]      tick_q,      tick_d;
   logic [BIT_IDX_W-1:0]  bit_idx_q,   bit_idx_d;
   logic [DATA_W-1:0]     shift_q,     shift_d;
   logic [DATA_W-1:0]     to_mem_q,    to_mem_d;
   logic                  rx_done_q,   rx_done_d;
   logic                  frame_err_q, frame_err_d;
   logic                  busy_q,      busy_d;

   uart_receiver_sync2 u_sync (
      .clk   (baudClk),
      .reset (reset),
      .d_i   (bus.rx),
      .q_o   (rx_sync)
   );

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge baudClk) begin
      if (reset) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         to_mem_q    <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         to_mem_q    <= to_mem_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and strobe logic; the tick counter restarts at 0 on every state entry.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      to_mem_d    = to_mem_q;
      rx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.en && !rx_sync) begin
               state_d = START_BIT;
               tick_d  = '0;
            end
         end

         START_BIT: begin
            if (tick_q == HALF_TGT) begin
               tick_d = '0;
               if (!rx_sync) begin
                  bit_idx_d = '0;
                  state_d   = DATA_BITS;
               end else begin
                  state_d   = IDLE;
               end
            end else begin
               tick_d = tick_q + CNT_ONE;
            end
         end

         DATA_BITS: begin
            if (tick_q == FULL_TGT) begin
               tick_d    = '0;
               shift_d   = {rx_sync, shift_q[DATA_W-1:1]};
               bit_idx_d = bit_idx_q + IDX_ONE;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP_BIT;
               end
            end else begin
               tick_d = tick_q + CNT_ONE;
            end
         end

         STOP_BIT: begin
            if (tick_q == FULL_TGT) begin
               tick_d = '0;
               if (rx_sync) begin
                  to_mem_d  = shift_q;
                  rx_done_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_BREAK;
               end
            end else begin
               tick_d = tick_q + CNT_ONE;
            end
         end

         RX_BREAK: begin
            // Hold off until the line idles so a break cannot retrigger.
            if (rx_sync) begin
               tick_d  = '0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.toMem    = to_mem_q;
   assign bus.rxDone   = rx_done_q;
   assign bus.frameErr = frame_err_q;
   assign bus.busy     = busy_q;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table rows, hand-written corner sequences and
// randomized line traffic compared with a mid-bit sampling model of the line.
module tb_uart_receiver;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      int         hold;
      bit         en;
      int         exp_done;
      int         exp_ferr;
      logic [7:0] exp_mem;
   } vec_t;

   typedef struct {
      time        t;
      bit         ferr;
      logic [7:0] data;
   } ev_t;

   logic baudClk;
   logic reset;

   uart_receiver_if bus ();

   uart_receiver #(.OVERSAMPLE(16), .CNT_W(4)) dut (
      .baudClk (baudClk),
      .reset   (reset),
      .bus     (bus)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   wave_q[$];
   bit   busy_log[$];
   ev_t  act_q[$];
   ev_t  exp_q[$];
   time  t0;
   logic [7:0] exp_mem;

   initial begin
      baudClk = 1'b0;
      forever #5 baudClk = ~baudClk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Record every strobe seen on the output side.
   always @(negedge baudClk) begin
      if (bus.rxDone || bus.frameErr) begin
         ev_t e;
         check("strobe_exclusive", 32'(bus.rxDone & bus.frameErr), 32'(0));
         e.t    = $time;
         e.ferr = bus.frameErr;
         e.data = bus.toMem;
         act_q.push_back(e);
      end
   end

   task automatic add_level(input bit v, input int n);
      repeat (n) wave_q.push_back(v);
   endtask

   // Start bit, eight data bits LSB first, then either a stop of stop_len
   // high cycles or a low stop bit followed by stop_len more low cycles.
   task automatic add_frame(input logic [7:0] d, input bit stop_ok, input int stop_len);
      add_level(1'b0, 16);
      for (int k = 0; k < 8; k++) add_level(d[k], 16);
      if (stop_ok) add_level(1'b1, stop_len);
      else         add_level(1'b0, 16 + stop_len);
   endtask

   function automatic bit pin(input int idx);
      return (idx < wave_q.size()) ? wave_q[idx] : 1'b1;
   endfunction

   // Line model: a low level while idle starts a frame whose bits are
   // sampled at their centres (8, 24+16n, 152 cycles after the first low);
   // the strobe appears 155 cycles after that first low cycle.
   task automatic model_run(input bit en_v, input time ts);
      int i;
      int j;
      ev_t e;
      exp_q.delete();
      i = 0;
      while (i < wave_q.size()) begin
         if (!en_v || pin(i)) begin
            i++;
         end else if (pin(i + 8)) begin
            i += 9;
         end else begin
            e.data = '0;
            for (int k = 0; k < 8; k++) e.data[k] = pin(i + 24 + 16 * k);
            e.t = ts + 10 * (i + 155);
            if (pin(i + 152)) begin
               e.ferr = 1'b0;
               exp_q.push_back(e);
               i += 153;
            end else begin
               e.ferr = 1'b1;
               e.data = '0;
               exp_q.push_back(e);
               j = i + 153;
               while (!pin(j)) j++;
               i = j + 1;
            end
         end
      end
   endtask

   // Drive wave_q one cycle per entry; optionally pulse reset at index rst_at.
   task automatic play(input bit en_v, input int rst_at);
      @(posedge baudClk);
      act_q.delete();
      busy_log.delete();
      for (int i = 0; i < wave_q.size(); i++) begin
         @(negedge baudClk);
         if (i == 0) t0 = $time;
         busy_log.push_back(bus.busy);
         if (rst_at >= 0 && i == rst_at + 1) begin
            check("rst_toMem",    32'(bus.toMem),    32'(0));
            check("rst_rxDone",   32'(bus.rxDone),   32'(0));
            check("rst_frameErr", 32'(bus.frameErr), 32'(0));
            check("rst_busy",     32'(bus.busy),     32'(0));
            reset = 1'b0;
         end
         if (rst_at >= 0 && i == rst_at) reset = 1'b1;
         bus.en = en_v;
         bus.rx = wave_q[i];
      end
      repeat (4) @(negedge baudClk);
   endtask

   task automatic compare_events(input string tag);
      int n;
      check({tag, "_ev_count"}, 32'(act_q.size()), 32'(exp_q.size()));
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s_ev%0d_time", tag, k), 32'(act_q[k].t), 32'(exp_q[k].t));
         check($sformatf("%s_ev%0d_kind", tag, k), 32'(act_q[k].ferr), 32'(exp_q[k].ferr));
         if (!exp_q[k].ferr)
            check($sformatf("%s_ev%0d_data", tag, k), 32'(act_q[k].data), 32'(exp_q[k].data));
      end
      foreach (exp_q[k]) if (!exp_q[k].ferr) exp_mem = exp_q[k].data;
   endtask

   initial begin
      vec_t vec[6];
      int   n_done;
      int   n_ferr;
      int   low_end;
      bit   busy_seen;
      int   nfr;
      int   kind;

      vec[0] = '{8'hA5, 1'b1,  0, 1'b1, 1, 0, 8'hA5};
      vec[1] = '{8'h3C, 1'b0, 40, 1'b1, 0, 1, 8'hA5};
      vec[2] = '{8'h55, 1'b1,  0, 1'b0, 0, 0, 8'hA5};
      vec[3] = '{8'h81, 1'b1,  0, 1'b1, 1, 0, 8'h81};
      vec[4] = '{8'h00, 1'b1,  0, 1'b1, 1, 0, 8'h00};
      vec[5] = '{8'hFF, 1'b1,  0, 1'b1, 1, 0, 8'hFF};

      reset  = 1'b1;
      bus.en = 1'b0;
      bus.rx = 1'b1;
      exp_mem = 8'h00;
      repeat (3) @(negedge baudClk);
      check("reset_toMem",    32'(bus.toMem),    32'(0));
      check("reset_rxDone",   32'(bus.rxDone),   32'(0));
      check("reset_frameErr", 32'(bus.frameErr), 32'(0));
      check("reset_busy",     32'(bus.busy),     32'(0));
      reset = 1'b0;

      // Table rows: one frame each, first low at index 10.
      for (int r = 0; r < 6; r++) begin
         wave_q.delete();
         add_level(1'b1, 10);
         add_frame(vec[r].data, vec[r].stop_ok, vec[r].stop_ok ? 16 : vec[r].hold);
         add_level(1'b1, 200);
         play(vec[r].en, -1);
         model_run(vec[r].en, t0);
         compare_events($sformatf("row%0d", r));
         n_done = 0;
         n_ferr = 0;
         foreach (act_q[k]) begin
            if (act_q[k].ferr) n_ferr++;
            else               n_done++;
         end
         check($sformatf("row%0d_done_count", r), 32'(n_done), 32'(vec[r].exp_done));
         check($sformatf("row%0d_ferr_count", r), 32'(n_ferr), 32'(vec[r].exp_ferr));
         check($sformatf("row%0d_toMem", r), 32'(bus.toMem), 32'(vec[r].exp_mem));
         if (!vec[r].stop_ok) begin
            low_end = 10 + 160 + vec[r].hold;
            check($sformatf("row%0d_busy_in_break", r), 32'(busy_log[low_end + 2]), 32'(1));
            check($sformatf("row%0d_busy_after_break", r), 32'(busy_log[low_end + 3]), 32'(0));
         end
         if (!vec[r].en) begin
            busy_seen = 1'b0;
            foreach (busy_log[k]) busy_seen |= busy_log[k];
            check($sformatf("row%0d_busy_disabled", r), 32'(busy_seen), 32'(0));
         end
         exp_mem = vec[r].exp_mem;
      end

      // Start glitch: 4 low cycles, start sample sees high.
      wave_q.delete();
      add_level(1'b1, 5);
      add_level(1'b0, 4);
      add_level(1'b1, 40);
      play(1'b1, -1);
      check("glitch_events", 32'(act_q.size()), 32'(0));
      check("glitch_busy_pre",  32'(busy_log[7]),  32'(0));
      check("glitch_busy_rise", 32'(busy_log[8]),  32'(1));
      check("glitch_busy_hold", 32'(busy_log[15]), 32'(1));
      check("glitch_busy_fall", 32'(busy_log[16]), 32'(0));
      check("glitch_toMem", 32'(bus.toMem), 32'(exp_mem));

      // Back-to-back frames with one-bit stop bits.
      wave_q.delete();
      add_level(1'b1, 10);
      add_frame(8'h00, 1'b1, 16);
      add_frame(8'hFF, 1'b1, 16);
      add_level(1'b1, 200);
      play(1'b1, -1);
      model_run(1'b1, t0);
      compare_events("b2b");
      check("b2b_count", 32'(act_q.size()), 32'(2));
      if (act_q.size() == 2) begin
         check("b2b_spacing", 32'(act_q[1].t - act_q[0].t), 32'(1600));
         check("b2b_first",   32'(act_q[0].data), 32'(8'h00));
         check("b2b_second",  32'(act_q[1].data), 32'(8'hFF));
      end
      check("b2b_toMem", 32'(bus.toMem), 32'(8'hFF));

      // Reset at receiver edge 60 of a 0x7E frame; line then idles.
      wave_q.delete();
      add_frame(8'h7E, 1'b1, 16);
      for (int k = 62; k < wave_q.size(); k++) wave_q[k] = 1'b1;
      add_level(1'b1, 100);
      play(1'b1, 62);
      check("abort_events", 32'(act_q.size()), 32'(0));
      check("abort_toMem", 32'(bus.toMem), 32'(0));
      exp_mem = 8'h00;

      wave_q.delete();
      add_level(1'b1, 10);
      add_frame(8'h42, 1'b1, 16);
      add_level(1'b1, 200);
      play(1'b1, -1);
      model_run(1'b1, t0);
      compare_events("after_reset");
      check("after_reset_toMem", 32'(bus.toMem), 32'(8'h42));

      // Randomized traffic: good frames, glitches and framing errors.
      for (int it = 0; it < 10; it++) begin
         wave_q.delete();
         add_level(1'b1, int'($urandom_range(5, 20)));
         nfr = int'($urandom_range(1, 3));
         for (int f = 0; f < nfr; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 2) begin
               add_level(1'b0, int'($urandom_range(1, 6)));
               add_level(1'b1, int'($urandom_range(10, 30)));
            end else if (kind == 2) begin
               add_frame(8'($urandom), 1'b0, int'($urandom_range(0, 30)));
               add_level(1'b1, int'($urandom_range(1, 20)));
            end else begin
               add_frame(8'($urandom), 1'b1, int'($urandom_range(16, 40)));
            end
         end
         add_level(1'b1, 200);
         play(1'b1, -1);
         model_run(1'b1, t0);
         compare_events($sformatf("rand%0d", it));
         check($sformatf("rand%0d_toMem", it), 32'(bus.toMem), 32'(exp_mem));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_receiver
